denise_bitplane_latch: RTL and testbench

Bus-side front end of the Denise bitplane path. It captures 16-bit BPLxDAT register writes for up to 8 planes and assembles them into 64-bit words according to the fetch mode. When plane 1 completes, it transfers all assembled words to a stable output bank and raises `load` toward the per-plane parallel-to-serial shifters. The load is aligned to the shifters' capture slot (`c1=0`, `c3=0`).

---
 rtl/denise_bitplane_latch_if.sv | 31 +++
 rtl/denise_bitplane_latch.sv | 147 ++++++++++++++
 tb/tb_denise_bitplane_latch.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/denise_bitplane_latch_if.sv
// denise_bitplane_latch_if: register-bus side and shifter-side signals
// master drives the bus, slave is the latch
`timescale 1ns/1ps
interface denise_bitplane_latch_if #(
  parameter int PLANES = 8
);
  logic                  clk7_en;
  logic                  c1;
  logic                  c3;
  logic [7:0]            reg_address_in;
  logic [15:0]           data_in;
  logic [1:0]            fmode;
  logic                  line_start;
  logic                  load;
  logic [64*PLANES-1:0]  bpl_data;
  logic                  armed;

  modport master (
    output clk7_en, c1, c3,
    output reg_address_in, data_in,
    output fmode, line_start,
    input  load, bpl_data, armed
  );

  modport slave (
    input  clk7_en, c1, c3,
    input  reg_address_in, data_in,
    input  fmode, line_start,
    output load, bpl_data, armed
  );
endinterface

// File: rtl/denise_bitplane_latch.sv
// denise_bitplane_latch: BPLxDAT capture, 64-bit assembly, shifter load
// Macro DENISE_BPL_AGA_EN enables fmode-driven 2/4-word fetches
`timescale 1ns/1ps
module denise_bitplane_latch #(
  parameter int         PLANES      = 8,
  parameter logic [7:0] BPLDAT_BASE = 8'h88
) (
  input  logic                    clk,
  input  logic                    reset_n,
  denise_bitplane_latch_if.slave  bus
);

  typedef enum logic {S_IDLE, S_PEND} state_t;

  state_t               r_state;
  logic                 r_load;
  logic                 r_armed;
  logic [64*PLANES-1:0] r_bank;
  logic [63:0]          r_hold     [PLANES];
  logic [63:0]          w_hold_nxt [PLANES];
  logic [PLANES-1:0]    w_wr;
  logic [PLANES-1:0]    w_done;
  logic                 w_capture;

`ifdef DENISE_BPL_AGA_EN
  logic [1:0] r_wc     [PLANES];
  logic [1:0] w_wc_nxt [PLANES];
  logic [1:0] w_idx    [PLANES];
  logic [1:0] w_last;

  // last word index of a fetch for the current fmode
  always_comb begin
    w_last = 2'd0;
    unique case (bus.fmode)
      2'b00:        w_last = 2'd0;
      2'b01, 2'b10: w_last = 2'd1;
      2'b11:        w_last = 2'd3;
    endcase
  end

  // slot select, first-word zeroing and counter advance per plane
  always_comb begin
    for (int n = 0; n < PLANES; n++) begin
      w_wr[n] = bus.clk7_en &&
        (bus.reg_address_in == BPLDAT_BASE + 8'(n));
      w_idx[n] = bus.line_start ? 2'd0 : r_wc[n];
      w_hold_nxt[n] = r_hold[n];
      w_wc_nxt[n] = w_idx[n];
      w_done[n] = 1'b0;
      if (w_wr[n]) begin
        if (w_idx[n] == 2'd0) begin
          if (w_last == 2'd0)
            w_hold_nxt[n][47:0] = '0;
          else if (w_last == 2'd1)
            w_hold_nxt[n][31:0] = '0;
        end
        unique case (w_idx[n])
          2'd0: w_hold_nxt[n][63:48] = bus.data_in;
          2'd1: w_hold_nxt[n][47:32] = bus.data_in;
          2'd2: w_hold_nxt[n][31:16] = bus.data_in;
          2'd3: w_hold_nxt[n][15:0]  = bus.data_in;
        endcase
        w_done[n] = (w_idx[n] == w_last);
        w_wc_nxt[n] = w_done[n] ? 2'd0 : w_idx[n] + 2'd1;
      end
    end
  end

  // word counters; line_start folds in through w_idx
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < PLANES; n++)
        r_wc[n] <= 2'd0;
    end else begin
      for (int n = 0; n < PLANES; n++)
        r_wc[n] <= w_wc_nxt[n];
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{bus.fmode, bus.line_start};

  // single-word fetch: every write lands in [63:48] and completes
  always_comb begin
    for (int n = 0; n < PLANES; n++) begin
      w_wr[n] = bus.clk7_en &&
        (bus.reg_address_in == BPLDAT_BASE + 8'(n));
      w_hold_nxt[n] = r_hold[n];
      w_done[n] = 1'b0;
      if (w_wr[n]) begin
        w_hold_nxt[n] = {bus.data_in, 48'h0};
        w_done[n] = 1'b1;
      end
    end
  end
`endif

  // per-plane holding registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < PLANES; n++)
        r_hold[n] <= '0;
    end else begin
      for (int n = 0; n < PLANES; n++)
        r_hold[n] <= w_hold_nxt[n];
    end
  end

  assign w_capture = r_load & ~bus.c1 & ~bus.c3;

  // transfer FSM: plane-1 completion arms, capture slot disarms
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_load  <= 1'b0;
      r_armed <= 1'b0;
      r_bank  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_done[0]) begin
            r_state <= S_PEND;
            r_load  <= 1'b1;
            r_armed <= 1'b1;
            for (int n = 0; n < PLANES; n++)
              r_bank[64*n +: 64] <= w_hold_nxt[n];
          end
        end
        S_PEND: begin
          if (w_done[0]) begin
            for (int n = 0; n < PLANES; n++)
              r_bank[64*n +: 64] <= w_hold_nxt[n];
          end else if (w_capture) begin
            r_state <= S_IDLE;
            r_load  <= 1'b0;
            r_armed <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.load     = r_load;
  assign bus.armed    = r_armed;
  assign bus.bpl_data = r_bank;

endmodule

// File: tb/tb_denise_bitplane_latch.sv
// tb_denise_bitplane_latch: directed + random stimulus vs fetch model
// Build with or without DENISE_BPL_AGA_EN
`timescale 1ns/1ps
module tb_denise_bitplane_latch;

  localparam int         PLANES = 8;
  localparam logic [7:0] BASE   = 8'h88;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  denise_bitplane_latch_if #(.PLANES(PLANES)) bus ();

  denise_bitplane_latch #(
    .PLANES      (PLANES),
    .BPLDAT_BASE (BASE)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [63:0] m_hold [PLANES];
  logic [63:0] m_bank [PLANES];
  int          m_wc   [PLANES];
  bit          m_pend;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  function automatic int words_of(input logic [1:0] fm);
`ifdef DENISE_BPL_AGA_EN
    if (fm == 2'b00) return 1;
    if (fm == 2'b11) return 4;
    return 2;
`else
    return (fm == 2'b00 || fm != 2'b00) ? 1 : 1;
`endif
  endfunction

  task automatic model_reset();
    for (int p = 0; p < PLANES; p++) begin
      m_hold[p] = '0;
      m_bank[p] = '0;
      m_wc[p]   = 0;
    end
    m_pend = 1'b0;
  endtask

  task automatic model_edge(input bit en, input logic [7:0] a,
                            input logic [15:0] d, input logic [1:0] fm,
                            input bit ls, input bit c1, input bit c3);
    int  w;
    int  idx;
    int  sh;
    bit  done1;
    done1 = 1'b0;
    w = words_of(fm);
    for (int p = 0; p < PLANES; p++) begin
      if (ls) m_wc[p] = 0;
      if (en && a == BASE + 8'(p)) begin
        idx = m_wc[p];
        sh  = 48 - 16 * idx;
        if (idx == 0 && w < 4)
          m_hold[p] &= ~((64'd1 << (64 - 16 * w)) - 64'd1);
        m_hold[p] = (m_hold[p] & ~(64'hFFFF << sh)) | (64'(d) << sh);
        if (idx == w - 1) begin
          m_wc[p] = 0;
          if (p == 0) done1 = 1'b1;
        end else begin
          m_wc[p] = (idx + 1) % 4;
        end
      end
    end
    if (done1) begin
      for (int p = 0; p < PLANES; p++) m_bank[p] = m_hold[p];
      m_pend = 1'b1;
    end else if (m_pend && !c1 && !c3) begin
      m_pend = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_load"}, 64'(bus.load), 64'(m_pend));
    chk({tag, "_armed"}, 64'(bus.armed), 64'(m_pend));
    for (int p = 0; p < PLANES; p++)
      chk($sformatf("%s_bpl%0d", tag, p + 1),
          bus.bpl_data[64*p +: 64], m_bank[p]);
  endtask

  task automatic step(input bit en, input logic [7:0] a,
                      input logic [15:0] d, input logic [1:0] fm,
                      input bit ls, input bit c1, input bit c3,
                      input string tag);
    bus.clk7_en        = en;
    bus.reg_address_in = a;
    bus.data_in        = d;
    bus.fmode          = fm;
    bus.line_start     = ls;
    bus.c1             = c1;
    bus.c3             = c3;
    @(posedge clk);
    model_edge(en, a, d, fm, ls, c1, c3);
    #1;
    check_all(tag);
  endtask

  task automatic mid_reset(input string tag);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk({tag, "_rst_load"}, 64'(bus.load), 64'd0);
    check_all(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  logic [7:0]  r_addr;
  logic [1:0]  r_fm;
  int          sel;

  initial begin
    bus.clk7_en        = 1'b0;
    bus.c1             = 1'b1;
    bus.c3             = 1'b1;
    bus.reg_address_in = 8'h00;
    bus.data_in        = 16'h0000;
    bus.fmode          = 2'b00;
    bus.line_start     = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    step(1, BASE + 8'd1, 16'hA5A5, 2'b00, 0, 1, 1, "f00_p2");
    step(1, BASE, 16'h1234, 2'b00, 0, 1, 1, "f00_p1");
    chk("f00_load", 64'(bus.load), 64'd1);
    chk("f00_plane1", bus.bpl_data[63:0], 64'h1234_0000_0000_0000);
    chk("f00_plane2", bus.bpl_data[127:64], 64'hA5A5_0000_0000_0000);
    step(0, 8'h00, 16'h0, 2'b00, 0, 0, 0, "f00_cap");
    chk("f00_cleared", 64'(bus.load), 64'd0);

`ifdef DENISE_BPL_AGA_EN
    step(1, BASE, 16'h1111, 2'b11, 0, 1, 1, "f11_w1");
    step(1, BASE, 16'h2222, 2'b11, 0, 1, 1, "f11_w2");
    step(1, BASE, 16'h3333, 2'b11, 0, 1, 1, "f11_w3");
    chk("f11_noload", 64'(bus.load), 64'd0);
    step(1, BASE, 16'h4444, 2'b11, 0, 1, 1, "f11_w4");
    chk("f11_load", 64'(bus.load), 64'd1);
    chk("f11_plane1", bus.bpl_data[63:0], 64'h1111_2222_3333_4444);
`else
    step(1, BASE, 16'h1111, 2'b11, 0, 1, 1, "ocs_f11");
    chk("ocs_load", 64'(bus.load), 64'd1);
    chk("ocs_plane1", bus.bpl_data[63:0], 64'h1111_0000_0000_0000);
`endif
    step(0, 8'h00, 16'h0, 2'b00, 0, 0, 0, "f11_cap");

    step(1, BASE, 16'hAAAA, 2'b01, 0, 1, 1, "f01_a");
`ifdef DENISE_BPL_AGA_EN
    chk("f01_noload", 64'(bus.load), 64'd0);
`endif
    step(0, 8'h00, 16'h0, 2'b01, 1, 1, 1, "f01_ls");
    step(1, BASE, 16'hBBBB, 2'b01, 0, 1, 1, "f01_b");
    step(1, BASE, 16'hCCCC, 2'b01, 0, 1, 1, "f01_c");
`ifdef DENISE_BPL_AGA_EN
    chk("f01_plane1", bus.bpl_data[63:0], 64'hBBBB_CCCC_0000_0000);
`endif
    step(0, 8'h00, 16'h0, 2'b01, 0, 0, 0, "f01_cap");

    step(1, BASE, 16'h5555, 2'b00, 0, 1, 1, "pend_1");
    step(1, BASE, 16'h6666, 2'b00, 0, 1, 1, "pend_2");
    chk("pend_load", 64'(bus.load), 64'd1);
    chk("pend_plane1", bus.bpl_data[63:0], 64'h6666_0000_0000_0000);
    step(0, 8'h00, 16'h0, 2'b00, 0, 0, 0, "pend_cap");
    step(0, 8'h00, 16'h0, 2'b00, 0, 0, 0, "pend_idle");
    chk("pend_single", 64'(bus.load), 64'd0);

    step(1, BASE + 8'd2, 16'hFFFF, 2'b00, 0, 1, 1, "rep_p3");
    step(1, BASE, 16'h0001, 2'b00, 0, 1, 1, "rep_p1a");
    step(0, 8'h00, 16'h0, 2'b00, 0, 0, 0, "rep_cap");
    step(1, BASE, 16'h0002, 2'b00, 0, 1, 1, "rep_p1b");
    chk("rep_plane3", bus.bpl_data[191:128], 64'hFFFF_0000_0000_0000);
    chk("rep_plane1", bus.bpl_data[63:0], 64'h0002_0000_0000_0000);

    chk("rst_pre_load", 64'(bus.load), 64'd1);
    mid_reset("rst_pend");

    r_fm = 2'b00;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 19) == 0) r_fm = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 13);
      if (sel < 6)       r_addr = BASE;
      else if (sel < 13) r_addr = BASE + 8'($urandom_range(1, 8));
      else               r_addr = 8'($urandom);
      step($urandom_range(0, 2) != 0, r_addr, 16'($urandom), r_fm,
           $urandom_range(0, 24) == 0,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd");
      if (i == 400) mid_reset("rnd_rst");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
